byte_serial_add_seq: RTL and testbench

- Sequential operand feeder and result collector for the 8-bit adder slice. Adds two NBYTES-wide operands by stepping one byte per cycle through a single external 8-bit adder.
- Carry is kept in a register between bytes.
- Optional approximate mode drops the carry into selected low bytes, to study the error/energy trade-off.
- Sits between the operand source (valid/ready) and the result consumer (valid/ready). It drives the adder's in1/in2/cin and captures its sum/cout.

---
 rtl/byte_serial_add_seq.sv | 112 +++++++++++
 tb/tb_byte_serial_add_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serial_add_seq.sv
// Byte-serial multi-byte adder sequencer: feeds one operand byte per cycle to an
// external 8-bit adder slice, keeps the carry between bytes, and collects the sum.
module byte_serial_add_seq #(
    parameter int NBYTES       = 4,
    parameter int APPROX_BYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  cin,
    input  logic                  approx_en,
    output logic [7:0]            add_in1,
    output logic [7:0]            add_in2,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   result,
    output logic                  result_cout
);

    localparam int IDXW = $clog2(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    // Bit i set means the carry into byte i is forced to zero in approximate mode.
    function automatic logic [NBYTES-1:0] build_approx_mask();
        logic [NBYTES-1:0] m;
        m = '0;
        for (int i = 1; i < NBYTES; i++) begin
            if (i <= APPROX_BYTES) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NBYTES-1:0] APPROX_MASK = build_approx_mask();

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                    state;
    logic [IDXW-1:0]           idx;
    logic                      carry_reg;
    logic                      approx_reg;
    logic [NBYTES-1:0][7:0]    a_reg;
    logic [NBYTES-1:0][7:0]    b_reg;
    logic [NBYTES-1:0][7:0]    result_bytes;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_bytes;

    // The adder inputs are held at zero outside RUN so the slice does not toggle.
    always_comb begin
        add_in1 = '0;
        add_in2 = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_in1 = a_reg[idx];
            add_in2 = b_reg[idx];
            add_cin = (approx_reg && APPROX_MASK[idx]) ? 1'b0 : carry_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            carry_reg    <= 1'b0;
            approx_reg   <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            result_bytes <= '0;
            result_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= op_a;
                        b_reg      <= op_b;
                        approx_reg <= approx_en;
                        carry_reg  <= cin;
                        idx        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    result_bytes[idx] <= add_sum;
                    carry_reg         <= add_cout;
                    if (idx == LAST_IDX) begin
                        result_cout <= add_cout;
                        idx         <= '0;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Self-checking bench for byte_serial_add_seq with a behavioural 8-bit adder slice
// closing the loop; directed table, random ops against a reference model, corner sequences.
module tb_byte_serial_add_seq;

    localparam int NBYTES       = 4;
    localparam int APPROX_BYTES = 2;
    localparam int W            = 8 * NBYTES;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          cin;
    logic          approx_en;
    logic [7:0]    add_in1;
    logic [7:0]    add_in2;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          result_cout;

    int n_compared;
    int n_mismatched;

    byte_serial_add_seq #(
        .NBYTES      (NBYTES),
        .APPROX_BYTES(APPROX_BYTES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .cin        (cin),
        .approx_en  (approx_en),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_cout(result_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + {8'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Approximate mode splits the sum into independent low bytes and one exact upper chunk.
    function automatic logic [W:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c, input logic apx);
        logic [W:0] r;
        logic [W:0] hi;
        logic [8:0] bs;
        if (!apx || APPROX_BYTES == 0) begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        end else begin
            r  = '0;
            hi = ({1'b0, a} >> (8 * APPROX_BYTES)) + ({1'b0, b} >> (8 * APPROX_BYTES));
            r  = hi << (8 * APPROX_BYTES);
            for (int i = 0; i < APPROX_BYTES; i++) begin
                bs = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + ((i == 0) ? {8'd0, c} : 9'd0);
                r[8*i +: 8] = bs[7:0];
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one operation and waits until out_valid, leaving the result unacknowledged.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic apx,
                                 output int latency, output logic [7:0] cin_trace);
        int guard;
        guard = 0;
        cin_trace = '0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        op_a = a; op_b = b; cin = c; approx_en = apx; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        latency = 0;
        while (!out_valid && latency < 20) begin
            if (latency < 8) cin_trace[latency] = add_cin;
            @(posedge clk);
            #1;
            latency++;
        end
        if (!out_valid) checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         apx;
        logic [W-1:0] exp_res;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        logic [7:0] trace;
        logic [W:0] exp;
        logic [W-1:0] ra, rb, held;
        logic rc, rx;

        n_compared = 0; n_mismatched = 0;
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFF00, 1'b0};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1};
        vecs[5] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; approx_en = 1'b0;
        #12;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_result_cout", 64'(result_cout), 64'd0);
        checkOutput("reset_adder_quiet", {47'd0, add_cin, add_in1, add_in2}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].apx, lat, trace);
            checkOutput($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].exp_res));
            checkOutput($sformatf("vec%0d_cout", i), 64'(result_cout), 64'(vecs[i].exp_cout));
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(NBYTES));
            if (vecs[i].apx && vecs[i].c) begin
                checkOutput($sformatf("vec%0d_add_cin_idx0", i), 64'(trace[0]), 64'd1);
                checkOutput($sformatf("vec%0d_add_cin_idx1", i), 64'(trace[1]), 64'd0);
                checkOutput($sformatf("vec%0d_add_cin_idx2", i), 64'(trace[2]), 64'd0);
            end
            releaseResult();
            checkOutput($sformatf("vec%0d_idle_quiet", i), {47'd0, add_cin, add_in1, add_in2}, 64'd0);
            checkOutput($sformatf("vec%0d_result_held", i), 64'(result), 64'(vecs[i].exp_res));
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rx = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            exp = refModel(ra, rb, rc, rx);
            applyStimulus(ra, rb, rc, rx, lat, trace);
            checkOutput($sformatf("rand%0d_sum", i), {31'd0, result_cout, result}, 64'(exp));
            releaseResult();
        end

        // Backpressure: result held in DONE while in_valid is pulsed with other operands.
        applyStimulus(32'hDEADBEEF, 32'h01020304, 1'b1, 1'b0, lat, trace);
        held = 32'hDEADBEEF + 32'h01020304 + 32'd1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = k[0]; op_a = 32'h55555555; op_b = 32'hAAAAAAAA;
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
            checkOutput($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
            checkOutput($sformatf("bp%0d_result", k), 64'(result), 64'(held));
        end
        in_valid = 1'b0;
        releaseResult();
        checkOutput("bp_back_to_idle", {62'd0, in_ready, out_valid}, 64'd2);
        applyStimulus(32'h00010000, 32'h0000FFFF, 1'b1, 1'b0, lat, trace);
        checkOutput("bp_next_op", {31'd0, result_cout, result}, 64'h0_00020000);
        releaseResult();

        // Reset in the middle of RUN, while idx = 2.
        @(negedge clk);
        op_a = 32'hFFFFFFFF; op_b = 32'h00000001; cin = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mid_result", 64'(result), 64'd0);
        checkOutput("rst_mid_result_cout", 64'(result_cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat, trace);
        checkOutput("rst_after_op", {31'd0, result_cout, result}, 64'h0_23456789);
        checkOutput("rst_after_latency", 64'(lat), 64'(NBYTES));
        releaseResult();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
